// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller that turns a 2**W-entry register file into a circular FIFO.
// Data never passes through here; only addresses, the write enable and status flags do.
module fifo_ctrl #(
  parameter int unsigned W        = 2,
  parameter int unsigned AF_LEVEL = 3,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic         clr_err,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0]   DEPTH_C = (W+1)'(2**W);
  localparam logic [W:0]   AF_C    = (W+1)'(AF_LEVEL);
  localparam logic [W:0]   AE_C    = (W+1)'(AE_LEVEL);
  localparam logic [W:0]   ONE_C   = (W+1)'(1);
  localparam logic [W-1:0] PTR1_C  = W'(1);

  logic [W-1:0] r_w_ptr;
  logic [W-1:0] r_r_ptr;
  logic [W:0]   r_count;
  logic         r_ovf;
  logic         r_udf;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Status decode and accept rules; a full FIFO still takes a push when a pop frees the head slot.
  always_comb begin
    w_full    = (r_count == DEPTH_C);
    w_empty   = (r_count == '0);
    w_push_ok = wr & (~w_full | rd);
    w_pop_ok  = rd & ~w_empty;
    w_ovf_evt = wr & ~w_push_ok;
    w_udf_evt = rd & ~w_pop_ok;
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_w_ptr <= r_w_ptr + PTR1_C;
      end
      if (w_pop_ok) begin
        r_r_ptr <= r_r_ptr + PTR1_C;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
      // A fresh error in the clearing cycle keeps the flag set.
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_evt) begin
        r_udf <= 1'b1;
      end else if (clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  // Output mapping; write enable is held off while reset is asserted.
  always_comb begin
    wr_en        = w_push_ok & ~reset;
    w_addr       = r_w_ptr;
    r_addr       = r_r_ptr;
    count        = r_count;
    full         = w_full;
    empty        = w_empty;
    almost_full  = (r_count >= AF_C);
    almost_empty = (r_count <= AE_C);
    overflow     = r_ovf;
    underflow    = r_udf;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed, table-driven bench for fifo_ctrl with a local 4x8 register file attached.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic       rd;
  logic       clr_err;
  logic       wr_en;
  logic [1:0] w_addr;
  logic [1:0] r_addr;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  logic [7:0] w_data;
  logic [7:0] r_data;
  logic [7:0] mem [0:3];

  int checks   = 0;
  int failures = 0;

  fifo_ctrl #(.W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
    .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end
  assign r_data = mem[r_addr];

  typedef struct {
    int wr, rd, clr, wd;
    int chk_rd, rd_exp, wren;
    int cnt, ovf, udf, wa, ra;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Status flags follow from the expected occupancy (depth 4, AF 3, AE 1).
  task automatic chk_state(input string tag, input int cnt, input int ovf, input int udf,
                           input int wa, input int ra);
    chk({tag, " count"}, int'(count), cnt);
    chk({tag, " full"}, int'(full), (cnt == 4) ? 1 : 0);
    chk({tag, " empty"}, int'(empty), (cnt == 0) ? 1 : 0);
    chk({tag, " almost_full"}, int'(almost_full), (cnt >= 3) ? 1 : 0);
    chk({tag, " almost_empty"}, int'(almost_empty), (cnt <= 1) ? 1 : 0);
    chk({tag, " overflow"}, int'(overflow), ovf);
    chk({tag, " underflow"}, int'(underflow), udf);
    chk({tag, " w_addr"}, int'(w_addr), wa);
    chk({tag, " r_addr"}, int'(r_addr), ra);
  endtask

  task automatic push_only(input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; rd = 1'b0; clr_err = 1'b0; w_data = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  initial begin
    //              wr rd clr wd    chk rdx   wren cnt ovf udf wa ra
    vecs.push_back('{0, 0, 0, 0,     0, 0,     0,   0,  0,  0,  0, 0});
    vecs.push_back('{0, 0, 0, 0,     0, 0,     0,   0,  0,  0,  0, 0});
    vecs.push_back('{1, 0, 0, 'h11,  0, 0,     1,   1,  0,  0,  1, 0});
    vecs.push_back('{1, 0, 0, 'h22,  0, 0,     1,   2,  0,  0,  2, 0});
    vecs.push_back('{1, 0, 0, 'h33,  0, 0,     1,   3,  0,  0,  3, 0});
    vecs.push_back('{1, 0, 0, 'h44,  0, 0,     1,   4,  0,  0,  0, 0});
    vecs.push_back('{1, 0, 0, 'h99,  0, 0,     0,   4,  1,  0,  0, 0});
    vecs.push_back('{0, 0, 1, 0,     0, 0,     0,   4,  0,  0,  0, 0});
    vecs.push_back('{0, 1, 0, 0,     1, 'h11,  0,   3,  0,  0,  0, 1});
    vecs.push_back('{0, 1, 0, 0,     1, 'h22,  0,   2,  0,  0,  0, 2});
    vecs.push_back('{0, 1, 0, 0,     1, 'h33,  0,   1,  0,  0,  0, 3});
    vecs.push_back('{0, 1, 0, 0,     1, 'h44,  0,   0,  0,  0,  0, 0});
    vecs.push_back('{0, 1, 0, 0,     0, 0,     0,   0,  0,  1,  0, 0});
    vecs.push_back('{0, 0, 1, 0,     0, 0,     0,   0,  0,  0,  0, 0});
    vecs.push_back('{0, 0, 1, 0,     0, 0,     0,   0,  0,  0,  0, 0});
    vecs.push_back('{1, 0, 0, 'h11,  0, 0,     1,   1,  0,  0,  1, 0});
    vecs.push_back('{1, 0, 0, 'h22,  0, 0,     1,   2,  0,  0,  2, 0});
    vecs.push_back('{1, 0, 0, 'h33,  0, 0,     1,   3,  0,  0,  3, 0});
    vecs.push_back('{1, 0, 0, 'h44,  0, 0,     1,   4,  0,  0,  0, 0});
    vecs.push_back('{1, 1, 0, 'h55,  1, 'h11,  1,   4,  0,  0,  1, 1});
    vecs.push_back('{0, 1, 0, 0,     1, 'h22,  0,   3,  0,  0,  1, 2});
    vecs.push_back('{0, 1, 0, 0,     1, 'h33,  0,   2,  0,  0,  1, 3});
    vecs.push_back('{0, 1, 0, 0,     1, 'h44,  0,   1,  0,  0,  1, 0});
    vecs.push_back('{0, 1, 0, 0,     1, 'h55,  0,   0,  0,  0,  1, 1});
    vecs.push_back('{1, 1, 0, 'hAA,  0, 0,     1,   1,  0,  1,  2, 1});
    vecs.push_back('{0, 1, 0, 0,     1, 'hAA,  0,   0,  0,  1,  2, 2});
    vecs.push_back('{0, 1, 1, 0,     0, 0,     0,   0,  0,  1,  2, 2});
    vecs.push_back('{0, 0, 1, 0,     0, 0,     0,   0,  0,  0,  2, 2});

    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = 8'h00;
    #1;
    chk("reset wr_en", int'(wr_en), 0);
    chk_state("reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      wr      = vecs[i].wr[0];
      rd      = vecs[i].rd[0];
      clr_err = vecs[i].clr[0];
      w_data  = vecs[i].wd[7:0];
      #1;
      chk($sformatf("v%0d wr_en", i), int'(wr_en), vecs[i].wren);
      if (vecs[i].chk_rd != 0) chk($sformatf("v%0d r_data", i), int'(r_data), vecs[i].rd_exp);
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf,
                vecs[i].wa, vecs[i].ra);
    end
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;

    // Three pushes, then an asynchronous reset in the low phase of the clock.
    push_only(8'hC1);
    push_only(8'hC2);
    push_only(8'hC3);
    chk("pre-reset count", int'(count), 3);
    @(negedge clk);
    #2;
    wr = 1'b1;
    reset = 1'b1;
    #1;
    chk("async count", int'(count), 0);
    chk("async empty", int'(empty), 1);
    chk("async w_addr", int'(w_addr), 0);
    chk("async r_addr", int'(r_addr), 0);
    chk("async wr_en", int'(wr_en), 0);
    @(posedge clk);
    #1;
    chk("held count", int'(count), 0);
    @(negedge clk);
    reset = 1'b0;
    wr = 1'b0;
    @(posedge clk);
    #1;
    chk_state("post-reset", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller that turns the Register_File (B-bit data, 2**W entries, synchronous write, combinational read) into a circular FIFO.
- Produces the register file's w_addr, r_addr and wr_en from push/pop requests.
- Tracks occupancy; reports full/empty, threshold flags and sticky overflow/underflow errors.
- Sits between producer/consumer logic and one Register_File instance; data buses connect directly to the register file, not through this block.

Parameters:
- W, 2: address bits; FIFO depth DEPTH = 2**W.
- AF_LEVEL, 3: almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  push request; data is presented on the register file's w_data in the same cycle.
- rd  input  1  pop request; head data is valid on the register file's r_data while empty=0.
- clr_err  input  1  synchronous clear of overflow/underflow.
- wr_en  output  1  write enable to register file; combinational.
- w_addr  output  W  write address; equals w_ptr.
- r_addr  output  W  read address; equals r_ptr.
- count  output  W+1  occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Reset (async, active-high): w_ptr=0, r_ptr=0, count=0, overflow=0, underflow=0.
  - Outputs during reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), wr_en=0.
  - Reset mid-operation discards all contents; register file data is not cleared.
- Registered state is w_ptr, r_ptr, count and the error flags.
  - full, empty and the almost flags decode combinationally from count.
  - w_addr and r_addr are the pointers themselves.
- Accept rules, evaluated each cycle from current state:
  - push_ok = wr & (~full | rd)
  - pop_ok = rd & ~empty
  - wr_en = push_ok (combinational, so the register file captures w_data on the same edge).
- Next state on clk rising edge:
  - push_ok: w_ptr <= w_ptr+1 (wraps mod DEPTH naturally in W bits).
  - pop_ok: r_ptr <= r_ptr+1 (wraps mod DEPTH).
  - count: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
- Simultaneous wr & rd:
  - Empty: only the push is accepted. r_data is not valid that cycle, the pop is rejected, and underflow is set. count becomes 1.
  - Full: both are accepted. The read of the head completes combinationally before the edge, and the write lands in the same slot (w_ptr==r_ptr). count stays DEPTH and overflow is not set.
  - Otherwise: both are accepted and count is unchanged.
- Error flags:
  - overflow <= 1 when wr & ~push_ok.
  - underflow <= 1 when rd & ~pop_ok.
  - Both clear to 0 on clr_err when no new error occurs that cycle. A new error in the same cycle as clr_err wins (flag stays 1).
- Latency: a pushed word is readable on r_data the cycle after its push edge, if it is at the head.
- Pointer wrap: after DEPTH pushes and DEPTH pops from reset, both pointers return to 0.

Test Plan:
- Reset, then idle for 2 cycles -> empty=1, full=0, count=0, w_addr=0, r_addr=0, wr_en=0, almost_empty=1.
- 4 pushes of 0x11,0x22,0x33,0x44 -> count steps 1,2,3,4; full=1 after the 4th; almost_full=1 from count=3. A 5th push gives wr_en=0, overflow=1, count=4, and contents unchanged.
- 4 pops -> r_data reads 0x11,0x22,0x33,0x44 in order; empty=1 afterwards. A 5th pop gives underflow=1, count=0, r_addr=0 (wrapped).
- Full FIFO, wr=1 and rd=1 with w_data=0x55 -> r_data=0x11 that cycle; count stays 4; w_addr and r_addr both advance to 1; overflow=0. Subsequent pops return 0x22,0x33,0x44,0x55.
- Empty FIFO, wr=1 and rd=1 with w_data=0xAA -> count=1, r_addr unchanged, underflow=1. The next pop returns 0xAA.
- Assert reset asynchronously mid-cycle with count=3 -> count=0 and empty=1 immediately, without waiting for a clock edge. Assert clr_err with no error pending -> overflow=0, underflow=0 on the next edge.
